cmd_bus_master: RTL and testbench
=================================

# cmd_bus_master

Byte-stream command decoder that acts as the initiator on the register bus of `main_memory`. It turns opcode/address/data frames received from the serial front end into single-cycle register writes and reads. It returns an ack byte for each write and the read word, MSB byte first, on a valid/ready byte stream toward the serial transmitter. It sits between the UART/SPI byte receiver/transmitter and `main_memory`.

## Interface
- `ADDR_WIDTH`, default 8: register address width; equals `` `ADDR_WIDTH `` in address_map.vh.
- `DATA_WIDTH`, default 32: register data width; equals `` `DATA_WIDTH ``, a multiple of 8; `NBYTES = DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 1_000_000: abort an incomplete frame after this many cycles with no byte; 0 disables the timeout.
- `i_clk`, input, 1: the single clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_rx_data`, input, 8: received byte.
- `i_rx_valid`, input, 1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_tx_data`, output, 8: response byte.
- `o_tx_valid`, output, 1: response byte is valid; held until accepted.
- `i_tx_ready`, input, 1: transmitter accepts the byte on a clock edge where `o_tx_valid && i_tx_ready`.
- `o_addr`, output, ADDR_WIDTH: register address, connects to `main_memory` `i_addr`.
- `o_data`, output, DATA_WIDTH: write data, connects to `i_data`.
- `o_wr`, output, 1: write strobe, connects to `i_wr`.
- `i_data`, input, DATA_WIDTH: read data, connects from `main_memory` `o_data`.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_err`, output, 1: one-cycle pulse on a protocol error.

## Operation
- **Frame format:** opcode byte, then address byte (low ADDR_WIDTH bits used), then, for writes only, NBYTES data bytes MSB first.
  - Opcode 0x01 = WRITE; 0x02 = READ.
  - Any other opcode in IDLE: byte dropped, `o_err` pulses, FSM stays in IDLE.
- **FSM states:**
  - IDLE: go to GET_ADDR on a valid opcode.
  - GET_ADDR: on a byte, go to GET_DATA for WRITE or RD_ADDR for READ.
  - GET_DATA: shift bytes in; after the NBYTES-th byte, go to WR_STB.
  - WR_STB: one cycle, go to SEND.
  - RD_ADDR: one cycle, go to RD_CAP.
  - RD_CAP: capture `i_data` into the shift register, go to SEND.
  - SEND: emit the queued bytes; go to IDLE after the last byte is accepted.
- **Write:** in WR_STB, `o_wr`=1 with `o_addr` and `o_data` valid. Response is one byte, 0xA5.
- **Read:** `o_wr`=0 throughout. Response is NBYTES bytes, MSB first.
- **Bus outputs:** `o_wr` is high only in WR_STB. `o_addr` and `o_data` hold their last values otherwise.
- **Rx bytes outside IDLE/GET_ADDR/GET_DATA** (WR_STB, RD_ADDR, RD_CAP, SEND): dropped, `o_err` pulses, state is unaffected.
- **Timeout:**
  - A cycle counter runs in GET_ADDR and GET_DATA and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to IDLE, `o_err` pulses, and no bus access occurs.
- **Reset** (synchronous, may hit mid-frame or mid-SEND): FSM to IDLE; the pending transaction and any unsent bytes are discarded.

## Timing
- **Reset values:** `o_addr`=0, `o_data`=0, `o_wr`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_err`=0, counters=0.
- **Write:**
  - Edge N samples the last data byte.
  - After N: `o_wr`=1, and `o_addr`/`o_data` are valid.
  - `main_memory` commits at edge N+1, when `o_wr` falls.
  - `o_tx_valid`=1 with `o_tx_data`=0xA5 from after edge N+1.
- **Read:**
  - Edge N samples the address byte; `o_addr` is valid after N.
  - `main_memory` registers its data at N+1.
  - `i_data` is captured at N+2.
  - `o_tx_valid`=1 with the MSB byte from after N+2.
- **Tx handshake:**
  - On an edge with `o_tx_valid && i_tx_ready`, the next byte appears after that edge, giving back-to-back bytes when ready is held high.
  - `o_tx_valid` drops after the last byte is accepted.
  - `o_tx_data` must not change while `o_tx_valid`=1 and `i_tx_ready`=0.
- **Minimum turnaround:** the next opcode is accepted in the cycle after the FSM returns to IDLE.
- **Simultaneous events:**
  - `i_rx_valid` in the same cycle the timeout expires: timeout wins and the byte is dropped.
  - `i_rst` overrides everything.

## Test plan
- Write frame 01 04 DE AD BE EF, `i_tx_ready`=1 -> exactly one cycle with `o_wr`=1, `o_addr`=0x04, `o_data`=0xDEADBEEF; then one byte 0xA5; `o_busy` returns to 0.
- Read frame 02 04, with the memory model returning 0x12345678 -> `o_wr` never high; tx bytes 12, 34, 56, 78 in order; first byte valid 2 cycles after the address byte.
- Read with `i_tx_ready` low for 5 cycles per byte -> `o_tx_data` is stable while stalled; no byte is lost or duplicated.
- Opcode 0x7F, then 02 01 -> `o_err` pulses once; the read of address 0x01 then completes normally.
- TIMEOUT_CYCLES=16, send 01 04 AA, then idle 16 cycles -> `o_err` pulses, FSM goes to IDLE, `o_wr` never asserts; a following 02 04 works.
- Assert `i_rst` for 1 cycle during SEND of a read -> the next cycle has `o_tx_valid`=0 and `o_busy`=0; no further tx bytes are sent.

Source files
------------

// File: rtl/cmd_bus_master.sv
// Byte-stream command decoder: turns opcode/address/data frames into single-cycle register
// bus writes/reads and streams back an ack byte or the read word, MSB byte first.
module cmd_bus_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned CW     = $clog2(NBYTES + 1);
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLimit = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [7:0] OpWrite = 8'h01;
  localparam logic [7:0] OpRead  = 8'h02;
  localparam logic [7:0] AckByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StWrStb, StRdAddr, StRdCap, StSend
  } state_e;

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_buf_q, addr_buf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;

  logic                  in_frame;
  logic                  tmo_expire;
  logic [DATA_WIDTH+7:0] cat;

  assign in_frame   = (state_q == StGetAddr) || (state_q == StGetData);
  assign tmo_expire = (TIMEOUT_CYCLES != 0) && in_frame && (tmo_q == TLimit);
  assign cat        = {shift_q, i_rx_data};

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_buf_d = addr_buf_q;
    addr_d     = addr_q;
    data_d     = data_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    err_d      = 1'b0;

    if (in_frame) begin
      tmo_d = i_rx_valid ? '0 : tmo_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          if (i_rx_data == OpWrite || i_rx_data == OpRead) begin
            is_wr_d = (i_rx_data == OpWrite);
            state_d = StGetAddr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StGetAddr: begin
        // Timeout takes priority over a byte arriving in the same cycle.
        if (tmo_expire) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (i_rx_valid) begin
          if (is_wr_q) begin
            addr_buf_d = ADDR_WIDTH'(i_rx_data);
            cnt_d      = '0;
            state_d    = StGetData;
          end else begin
            addr_d  = ADDR_WIDTH'(i_rx_data);
            state_d = StRdAddr;
          end
        end
      end
      StGetData: begin
        if (tmo_expire) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (i_rx_valid) begin
          shift_d = cat[DATA_WIDTH-1:0];
          if (cnt_q == CW'(NBYTES - 1)) begin
            // Bus outputs only change once the whole frame is in.
            data_d  = cat[DATA_WIDTH-1:0];
            addr_d  = addr_buf_q;
            cnt_d   = '0;
            state_d = StWrStb;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWrStb: begin
        shift_d                     = '0;
        shift_d[DATA_WIDTH-1 -: 8]  = AckByte;
        cnt_d                       = CW'(1);
        state_d                     = StSend;
      end
      StRdAddr: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        shift_d = i_data;
        cnt_d   = CW'(NBYTES);
        state_d = StSend;
      end
      StSend: begin
        if (i_tx_ready) begin
          if (cnt_q == CW'(1)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_rx_valid && !in_frame && state_q != StIdle) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      addr_buf_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_buf_q <= addr_buf_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_wr       = (state_q == StWrStb);
  assign o_busy     = (state_q != StIdle);
  assign o_tx_valid = (state_q == StSend);
  assign o_tx_data  = shift_q[DATA_WIDTH-1 -: 8];
  assign o_err      = err_q;

endmodule

// File: tb/tb_cmd_bus_master.sv
// Self-checking bench for cmd_bus_master: directed scenarios plus randomized traffic
// checked against a word-level register model.
module tb_cmd_bus_master;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst, rx_valid, tx_ready;
  logic [7:0]    rx_data;
  logic [7:0]    tx_data;
  logic          tx_valid, wr, busy, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rd_data;

  always #5 clk = ~clk;

  cmd_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_addr(addr), .o_data(wdata), .o_wr(wr), .i_data(rd_data),
    .o_busy(busy), .o_err(err)
  );

  // Stand-in for main_memory: write on o_wr, registered read.
  logic [DW-1:0] env_mem [256];
  always @(posedge clk) begin
    if (wr) env_mem[addr] <= wdata;
    rd_data <= env_mem[addr];
  end

  // Reference register contents, updated per completed write frame.
  logic [DW-1:0] ref_mem [256];

  logic [7:0]    tx_q[$];
  int            wr_cnt = 0, err_cnt = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (wr) begin
      wr_cnt++;
      wr_addr = addr;
      wr_data = wdata;
    end
    if (err) err_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic gap(input bit rnd);
    if (rnd) repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic send_write(input logic [7:0] a, input logic [DW-1:0] d, input bit rnd);
    send_byte(8'h01); gap(rnd);
    send_byte(a);
    for (int i = NB - 1; i >= 0; i--) begin
      gap(rnd);
      send_byte(d[i*8 +: 8]);
    end
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (!busy) ok = 1'b1;
    tx_ready = 1'b1;
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    tests++;
    if (tx_q.size() != exp.size()) begin
      fails++;
      $display("FAIL %s count: got %0d expected %0d", name, tx_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests++;
        if (tx_q[i] !== exp[i]) begin
          fails++;
          $display("FAIL %s byte %0d: got %h expected %h", name, i, tx_q[i], exp[i]);
        end
      end
    end
  endtask

  function automatic void word_bytes(input logic [DW-1:0] w, output logic [7:0] q[$]);
    q.delete();
    for (int i = NB - 1; i >= 0; i--) q.push_back(w[i*8 +: 8]);
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    tick(); tick();
    tests++; if (addr !== '0)     begin fails++; $display("FAIL reset o_addr: got %h expected 0", addr); end
    tests++; if (wdata !== '0)    begin fails++; $display("FAIL reset o_data: got %h expected 0", wdata); end
    tests++; if (wr !== 1'b0)     begin fails++; $display("FAIL reset o_wr: got %b expected 0", wr); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset o_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset o_tx_data: got %h expected 00", tx_data); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset o_busy: got %b expected 0", busy); end
    tests++; if (err !== 1'b0)    begin fails++; $display("FAIL reset o_err: got %b expected 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int w0;
    logic [7:0] exp[$];
    tx_ready = 1'b1; tx_q.delete(); w0 = wr_cnt;
    send_write(8'h04, 32'hDEADBEEF, 1'b0);
    tests++; if (wr !== 1'b1) begin fails++; $display("FAIL write strobe: got %b expected 1", wr); end
    tests++; if (addr !== 8'h04) begin fails++; $display("FAIL write addr: got %h expected 04", addr); end
    tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL write data: got %h expected deadbeef", wdata); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL write early ack: got %b expected 0", tx_valid); end
    tick();
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL write strobe drop: got %b expected 0", wr); end
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      fails++; $display("FAIL write ack: got v=%b d=%h expected v=1 d=a5", tx_valid, tx_data);
    end
    tick();
    tests++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL write done: got v=%b busy=%b expected 0 0", tx_valid, busy);
    end
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL write strobe count: got %0d expected 1", wr_cnt - w0); end
    ref_mem[4] = 32'hDEADBEEF;
    exp = '{8'hA5};
    check_bytes("write ack", exp);
  endtask

  task automatic test_read();
    bit ok;
    int w0;
    logic [7:0] exp[$];
    tx_ready = 1'b1;
    send_write(8'h04, 32'h12345678, 1'b0);
    wait_idle(20, 1'b0, ok);
    ref_mem[4] = 32'h12345678;
    tx_q.delete(); w0 = wr_cnt;
    send_byte(8'h02);
    send_byte(8'h04);
    tests++; if (busy !== 1'b1 || addr !== 8'h04 || tx_valid !== 1'b0) begin
      fails++; $display("FAIL read addr phase: got busy=%b addr=%h v=%b expected 1 04 0", busy, addr, tx_valid);
    end
    tick();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL read early valid: got %b expected 0", tx_valid); end
    tick();
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin
      fails++; $display("FAIL read first byte: got v=%b d=%h expected v=1 d=12", tx_valid, tx_data);
    end
    wait_idle(20, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL read completion: got busy expected idle"); end
    tests++; if (wr_cnt !== w0) begin fails++; $display("FAIL read wr asserted: got %0d expected %0d", wr_cnt, w0); end
    word_bytes(ref_mem[4], exp);
    check_bytes("read bytes", exp);
  endtask

  task automatic test_stall();
    bit ok;
    logic [7:0] a, hold;
    logic [DW-1:0] d;
    logic [7:0] exp[$];
    a = 8'($urandom_range(8, 255)); d = $urandom();
    tx_ready = 1'b1;
    send_write(a, d, 1'b1);
    wait_idle(40, 1'b0, ok);
    ref_mem[a] = d;
    tx_q.delete(); tx_ready = 1'b0;
    send_byte(8'h02);
    send_byte(a);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL stall valid: got %b expected 1", tx_valid); end
    word_bytes(d, exp);
    for (int k = 0; k < NB; k++) begin
      hold = tx_data;
      tests++; if (hold !== exp[k]) begin fails++; $display("FAIL stall byte %0d: got %h expected %h", k, hold, exp[k]); end
      repeat (5) begin
        tick();
        tests++; if (tx_valid !== 1'b1 || tx_data !== hold) begin
          fails++; $display("FAIL stall hold: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, hold);
        end
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stall done: got busy=%b expected 0", busy); end
    check_bytes("stall bytes", exp);
    tx_ready = 1'b1;
  endtask

  task automatic test_bad_opcode();
    bit ok;
    int e0;
    logic [DW-1:0] d;
    logic [7:0] exp[$];
    d = $urandom(); tx_ready = 1'b1;
    send_write(8'h01, d, 1'b0);
    wait_idle(20, 1'b0, ok);
    ref_mem[1] = d;
    tx_q.delete(); e0 = err_cnt;
    send_byte(8'h7F);
    send_byte(8'h02);
    send_byte(8'h01);
    wait_idle(20, 1'b0, ok);
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL badop err count: got %0d expected 1", err_cnt - e0); end
    word_bytes(ref_mem[1], exp);
    check_bytes("badop read", exp);
  endtask

  task automatic test_timeout();
    bit ok;
    int e0, w0;
    logic [7:0] exp[$];
    tx_ready = 1'b1; e0 = err_cnt; w0 = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'hAA);
    repeat (TMO - 1) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout early: got busy=%b expected 1", busy); end
    tick();
    tests++; if (busy !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL timeout expire: got busy=%b err=%b expected 0 1", busy, err);
    end
    repeat (3) tick();
    tests++; if (err_cnt - e0 !== 1 || wr_cnt !== w0) begin
      fails++; $display("FAIL timeout effects: got err=%0d wr=%0d expected 1 0", err_cnt - e0, wr_cnt - w0);
    end
    tx_q.delete();
    send_byte(8'h02);
    send_byte(8'h04);
    wait_idle(20, 1'b0, ok);
    word_bytes(ref_mem[4], exp);
    check_bytes("post-timeout read", exp);
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    logic [DW-1:0] d;
    d = $urandom(); tx_ready = 1'b1;
    send_write(8'h07, d, 1'b0);
    wait_idle(20, 1'b0, ok);
    ref_mem[7] = d;
    tx_q.delete(); tx_ready = 1'b0;
    send_byte(8'h02);
    send_byte(8'h07);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mid-send reset: got v=%b busy=%b expected 0 0", tx_valid, busy);
    end
    tx_ready = 1'b1;
    repeat (10) tick();
    tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL mid-send leak: got %0d bytes expected 0", tx_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int w0;
    logic [7:0] a;
    logic [DW-1:0] d;
    logic [7:0] exp[$];
    for (int n = 0; n < 30; n++) begin
      tx_q.delete(); w0 = wr_cnt;
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        send_write(a, d, 1'b1);
        ref_mem[a] = d;
        exp = '{8'hA5};
        wait_idle(200, 1'b1, ok);
        tests++; if (wr_cnt - w0 !== 1 || wr_addr !== a || wr_data !== d) begin
          fails++; $display("FAIL rand write %0d: got n=%0d a=%h d=%h expected 1 %h %h",
                            n, wr_cnt - w0, wr_addr, wr_data, a, d);
        end
      end else begin
        send_byte(8'h02); gap(1'b1);
        send_byte(a);
        word_bytes(ref_mem[a], exp);
        wait_idle(200, 1'b1, ok);
        tests++; if (wr_cnt !== w0) begin fails++; $display("FAIL rand read %0d wr: got %0d expected 0", n, wr_cnt - w0); end
      end
      tests++; if (!ok) begin fails++; $display("FAIL rand op %0d: got busy expected idle", n); end
      check_bytes("rand op", exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    rd_data = '0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
